// File: rtl/packet_to_adc.sv
// packet_to_adc: receive-side unpacker for ADC sample packets.
// Pops bytes from an FWFT FIFO, validates the 4-byte header (version,
// sample count), then presents pSamplesPerPacket 8x16-bit samples, one per
// valid/ready handshake. A rejected header drops the remaining payload so
// the parser stays aligned to packet boundaries.
// Optional feature macro: PACKET_SEQ_CHECK_EN (adds oSeqErr sequence check).
module packet_to_adc #(
  parameter int unsigned pPacketSize       = 244,
  parameter int unsigned pPacketVersion    = 0,
  parameter int unsigned pSamplesPerPacket = 15,
  parameter int unsigned pAdcDataWidth     = 16
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic [7:0]   iRdData,
  input  logic         iRdEmpty,
  output logic         oRdEn,
  output logic [127:0] oAdcSampleData,
  output logic         oSampleValid,
  input  logic         iSampleReady,
  output logic [15:0]  oSeqNum,
  output logic         oPacketDone,
  output logic         oErr
`ifdef PACKET_SEQ_CHECK_EN
  ,
  output logic         oSeqErr
`endif
);

  localparam logic [7:0]  VERSION     = 8'(pPacketVersion);
  localparam logic [7:0]  SAMPLES     = 8'(pSamplesPerPacket);
  localparam logic [7:0]  LAST_SAMPLE = 8'(pSamplesPerPacket - 1);
  localparam logic [11:0] DROP_BYTES  = 12'(pSamplesPerPacket * 16);

  if (pPacketSize != 4 + pSamplesPerPacket * pAdcDataWidth) begin : g_bad_size
    $error("packet_to_adc: pPacketSize must equal 4 + pSamplesPerPacket*pAdcDataWidth");
  end
  if (pAdcDataWidth != 16) begin : g_bad_width
    $error("packet_to_adc: pAdcDataWidth must be 16");
  end
  if (pSamplesPerPacket < 1 || pSamplesPerPacket > 255) begin : g_bad_count
    $error("packet_to_adc: pSamplesPerPacket must be 1..255");
  end

  typedef enum logic [1:0] {
    ST_HDR,
    ST_DATA,
    ST_PRESENT,
    ST_DROP
  } state_e;

  state_e         state_q;
  logic [1:0]     hdr_cnt_q;
  logic [7:0]     hdr_b0_q;
  logic [7:0]     hdr_b1_q;
  logic [7:0]     hdr_b2_q;
  logic [3:0]     byte_cnt_q;
  logic [119:0]   asm_q;
  logic [7:0]     sample_cnt_q;
  logic [11:0]    drop_cnt_q;
  logic [127:0]   data_q;
  logic           valid_q;
  logic [15:0]    seq_q;
  logic           done_q;
  logic           err_q;
  logic           take;
  logic [15:0]    rx_seq;

`ifdef PACKET_SEQ_CHECK_EN
  logic           seq_vld_q;
  logic [15:0]    seq_exp_q;
  logic           seq_err_q;
`endif

  // Pop whenever the FIFO has data and the parser is consuming bytes.
  always_comb begin
    oRdEn = iRst_n & ~iRdEmpty & (state_q != ST_PRESENT);
  end

  assign take   = oRdEn;
  assign rx_seq = {iRdData, hdr_b2_q};

  // Header / payload parser FSM with registered outputs.
  // Only 15 sample bytes are buffered; the 16th is merged straight into the
  // output register on the completing pop.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= ST_HDR;
      hdr_cnt_q    <= '0;
      hdr_b0_q     <= '0;
      hdr_b1_q     <= '0;
      hdr_b2_q     <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      seq_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef PACKET_SEQ_CHECK_EN
      seq_vld_q    <= 1'b0;
      seq_exp_q    <= '0;
      seq_err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef PACKET_SEQ_CHECK_EN
      seq_err_q <= 1'b0;
`endif
      case (state_q)
        ST_HDR: begin
          if (take) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            case (hdr_cnt_q)
              2'd0: hdr_b0_q <= iRdData;
              2'd1: hdr_b1_q <= iRdData;
              2'd2: hdr_b2_q <= iRdData;
              default: begin
                if (hdr_b0_q == VERSION && hdr_b1_q == SAMPLES) begin
                  seq_q        <= rx_seq;
                  sample_cnt_q <= '0;
                  byte_cnt_q   <= '0;
                  state_q      <= ST_DATA;
`ifdef PACKET_SEQ_CHECK_EN
                  if (seq_vld_q && rx_seq != seq_exp_q) begin
                    seq_err_q <= 1'b1;
                  end
                  seq_exp_q <= rx_seq + 16'd1;
                  seq_vld_q <= 1'b1;
`endif
                end else begin
                  err_q      <= 1'b1;
                  drop_cnt_q <= DROP_BYTES;
                  state_q    <= ST_DROP;
                end
              end
            endcase
          end
        end
        ST_DATA: begin
          if (take) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
              data_q  <= {iRdData, asm_q};
              valid_q <= 1'b1;
              state_q <= ST_PRESENT;
            end else begin
              asm_q <= {iRdData, asm_q[119:8]};
            end
          end
        end
        ST_PRESENT: begin
          if (iSampleReady) begin
            valid_q      <= 1'b0;
            sample_cnt_q <= sample_cnt_q + 8'd1;
            if (sample_cnt_q == LAST_SAMPLE) begin
              done_q  <= 1'b1;
              state_q <= ST_HDR;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DROP: begin
          if (take) begin
            drop_cnt_q <= drop_cnt_q - 12'd1;
            if (drop_cnt_q == 12'd1) begin
              state_q <= ST_HDR;
            end
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  assign oAdcSampleData = data_q;
  assign oSampleValid   = valid_q;
  assign oSeqNum        = seq_q;
  assign oPacketDone    = done_q;
  assign oErr           = err_q;
`ifdef PACKET_SEQ_CHECK_EN
  assign oSeqErr        = seq_err_q;
`endif

endmodule
